// File: rtl/stats_snapshot_ctrl.sv
// Captures a coherent snapshot of the statistics counter bank and streams it
// word-by-word, tagged with its index, into one shared clock-crossing synchronizer.
module stats_snapshot_ctrl #(
  parameter int SIZE        = 64,
  parameter int N_CNT       = 7,
  parameter int IDX_W       = 3,
  parameter int AUTO_PERIOD = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    snap_req,
  input  logic                    clr_ovr,
  input  logic [N_CNT*SIZE-1:0]   cnt_in,
  output logic [IDX_W+SIZE-1:0]   sync_din,
  output logic                    sync_din_vld,
  input  logic                    sync_din_rdy,
  output logic                    busy,
  output logic                    snap_done,
  output logic [15:0]             snap_seq,
  output logic                    overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNT - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [SIZE-1:0]  bank [N_CNT];
  logic             pending;
  logic             auto_tick;
  logic             req;
  logic             capture;

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
      logic [AW-1:0] auto_cnt;

      always_ff @(posedge clk) begin
        if (!rst_n)                    auto_cnt <= '0;
        else if (auto_cnt == AUTO_LAST) auto_cnt <= '0;
        else                           auto_cnt <= auto_cnt + AW'(1);
      end

      assign auto_tick = (auto_cnt == AUTO_LAST);
    end else begin : g_no_auto
      assign auto_tick = 1'b0;
    end
  endgenerate

  assign req = snap_req | auto_tick;

  // A request in DONE (or a queued one) reloads the bank at the DONE exit edge.
  assign capture = ((state == IDLE) && req) || ((state == DONE) && (pending || req));

  // NOTE: the bank is an addressable array, but it still gets an explicit reset
  // loop so a snapshot abandoned by reset can never leak stale counter values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CNT; i++) bank[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_CNT; i++) bank[i] <= cnt_in[i*SIZE +: SIZE];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every branch below
  // sees the pre-edge values of state, idx and pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      snap_seq <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (sync_din_rdy) begin
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          snap_seq <= snap_seq + 16'd1;
          if (pending || req) begin
            idx   <= '0;
            state <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == DONE)             pending <= 1'b0;
      else if (state == SEND && req) pending <= 1'b1;

      // A drop in the same cycle as clr_ovr must leave overrun set.
      if (clr_ovr) overrun <= 1'b0;
      if (req && pending && (state != IDLE)) overrun <= 1'b1;
    end
  end

  assign sync_din_vld = (state == SEND);
  assign sync_din     = sync_din_vld ? {idx, bank[idx]} : '0;
  assign busy         = (state != IDLE);
  assign snap_done    = (state == DONE);

endmodule

// File: tb/tb_stats_snapshot_ctrl.sv
// Bench for stats_snapshot_ctrl: a transaction-level model predicts each captured
// snapshot into a queue, and a negedge monitor pops and compares every handshaked word.
module tb_stats_snapshot_ctrl;

  localparam int SIZE  = 64;
  localparam int N_CNT = 7;
  localparam int IDX_W = 3;
  localparam int W     = IDX_W + SIZE;

  typedef logic [W-1:0] word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n    = 1'b0;
  logic                  rst_a_n  = 1'b0;
  logic                  snap_req = 1'b0;
  logic                  clr_ovr  = 1'b0;
  logic                  rdy      = 1'b0;
  logic [N_CNT*SIZE-1:0] cnt_in   = '0;

  word_t       sync_din, a_din;
  logic        vld, busy, done, ovr;
  logic        a_vld, a_busy, a_done, a_ovr;
  logic [15:0] seq, a_seq;

  stats_snapshot_ctrl #(.SIZE(SIZE), .N_CNT(N_CNT), .IDX_W(IDX_W), .AUTO_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .clr_ovr(clr_ovr), .cnt_in(cnt_in),
    .sync_din(sync_din), .sync_din_vld(vld), .sync_din_rdy(rdy),
    .busy(busy), .snap_done(done), .snap_seq(seq), .overrun(ovr)
  );

  stats_snapshot_ctrl #(.SIZE(SIZE), .N_CNT(N_CNT), .IDX_W(IDX_W), .AUTO_PERIOD(20)) dut_auto (
    .clk(clk), .rst_n(rst_a_n), .snap_req(1'b0), .clr_ovr(1'b0), .cnt_in(cnt_in),
    .sync_din(a_din), .sync_din_vld(a_vld), .sync_din_rdy(1'b1),
    .busy(a_busy), .snap_done(a_done), .snap_seq(a_seq), .overrun(a_ovr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: words still to send in the active snapshot, whether the
  // completion cycle is under way, one queued request, sticky drop flag, count.
  int          m_left    = 0;
  bit          m_closing = 1'b0;
  bit          m_queued  = 1'b0;
  bit          m_ovr     = 1'b0;
  logic [15:0] m_seq     = '0;
  word_t       exp_q[$];

  task automatic model_step();
    bit drop, start;
    drop  = 1'b0;
    start = 1'b0;
    if (!rst_n) begin
      m_left = 0; m_closing = 1'b0; m_queued = 1'b0; m_ovr = 1'b0; m_seq = '0;
      exp_q.delete();
      return;
    end
    if (m_closing) begin
      m_seq     = m_seq + 16'd1;
      m_closing = 1'b0;
      if (snap_req && m_queued) drop = 1'b1;
      if (m_queued || snap_req) begin
        m_queued = 1'b0;
        start    = 1'b1;
      end
    end else if (m_left > 0) begin
      if (snap_req) begin
        if (m_queued) drop = 1'b1;
        else          m_queued = 1'b1;
      end
      if (rdy) begin
        m_left--;
        if (m_left == 0) m_closing = 1'b1;
      end
    end else if (snap_req) begin
      start = 1'b1;
    end
    if (start) begin
      for (int i = 0; i < N_CNT; i++) exp_q.push_back({IDX_W'(i), cnt_in[i*SIZE +: SIZE]});
      m_left = N_CNT;
    end
    if (clr_ovr) m_ovr = 1'b0;
    if (drop)    m_ovr = 1'b1;
  endtask

  // Inputs only ever change 1 ns after a rising edge; the model sees exactly
  // what the DUT samples at that edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    snap_req = 1'b0;
    clr_ovr  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_cnt();
    for (int i = 0; i < N_CNT; i++) cnt_in[i*SIZE +: SIZE] = {$urandom, $urandom};
  endtask

  task automatic bump_cnt();
    for (int i = 0; i < N_CNT; i++) cnt_in[i*SIZE +: SIZE] = cnt_in[i*SIZE +: SIZE] + 64'd1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    tick();
    rdy      = 1'b1;
    snap_req = 1'b0;
    clr_ovr  = 1'b0;
    while ((m_left > 0 || m_closing) && n < 100) begin
      tick();
      n++;
    end
    tick();
    @(negedge clk);
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: per-cycle control outputs against the model, plus scoreboard pops.
  initial begin
    word_t prev_din;
    bit    prev_hold;
    prev_hold = 1'b0;
    prev_din  = '0;
    forever begin
      @(negedge clk);
      check("vld",     vld,  m_left > 0);
      check("done",    done, m_closing);
      check("busy",    busy, (m_left > 0) || m_closing);
      check("seq",     seq,  m_seq);
      check("overrun", ovr,  m_ovr);
      if (!vld) check("din_when_idle", sync_din, 0);
      if (prev_hold) begin
        check("hold_vld", vld, 1'b1);
        check("hold_din", sync_din, prev_din);
      end
      prev_hold = vld && !rdy && rst_n;
      prev_din  = sync_din;
      if (vld && rdy && rst_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL word_unexpected: got %0h expected no word", sync_din);
        end else begin
          check("word", sync_din, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w0;
    int    done_cnt;
    int    done_cyc[$];

    // Reset state and the basic latency scenario.
    do_reset();
    @(negedge clk);
    check("rst_din",  sync_din, 0);
    check("rst_seq",  seq, 16'd0);
    check("rst_ovr",  ovr, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < N_CNT; i++) cnt_in[i*SIZE +: SIZE] = 64'h1000 + 64'(i);
    rdy = 1'b1;
    repeat (10) tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    @(negedge clk);
    check("t1_c11_vld",  vld, 1'b1);
    check("t1_c11_word", sync_din, {3'd0, 64'h1000});
    repeat (6) tick();
    @(negedge clk);
    check("t1_c17_word", sync_din, {3'd6, 64'h1006});
    tick();
    @(negedge clk);
    check("t1_c18_done", done, 1'b1);
    tick();
    @(negedge clk);
    check("t1_c19_seq",  seq, 16'd1);
    check("t1_c19_busy", busy, 1'b0);

    // Coherency: counters move every cycle, rdy toggles 1010...
    do_reset();
    rand_cnt();
    repeat (3) tick();
    rdy      = 1'b1;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    bump_cnt();
    repeat (20) begin
      tick();
      bump_cnt();
      rdy = ~rdy;
    end
    drain("coherency");

    // Back-to-back requests at cycles 10, 12, 14.
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      snap_req = (c == 10) || (c == 12) || (c == 14);
      rand_cnt();
      tick();
    end
    snap_req = 1'b0;
    @(negedge clk);
    check("b2b_overrun", ovr, 1'b1);
    check("b2b_seq",     seq, 16'd2);
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    @(negedge clk);
    check("b2b_clr_ovr", ovr, 1'b0);

    // Reset after word 3, with one request pending and one dropped.
    do_reset();
    rand_cnt();
    rdy = 1'b1;
    repeat (5) tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    @(negedge clk);
    check("mid_ovr_before", ovr, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_vld_fall", vld, 1'b0);
    check("mid_seq",      seq, 16'd0);
    check("mid_ovr",      ovr, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("mid_no_resume", busy, 1'b0);
    tick();
    rand_cnt();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    @(negedge clk);
    check("mid_restart_word", sync_din, {3'd0, cnt_in[0 +: SIZE]});
    drain("mid");

    // Long stall: word 0 must stay put and no completion may be reported.
    do_reset();
    rand_cnt();
    rdy = 1'b0;
    repeat (2) tick();
    w0       = {3'd0, cnt_in[0 +: SIZE]};
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      tick();
    end
    @(negedge clk);
    check("stall_vld",     vld, 1'b1);
    check("stall_word",    sync_din, w0);
    check("stall_no_done", done_cnt, 0);
    drain("stall");

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      snap_req = ($urandom_range(0, 7) == 0);
      rdy      = ($urandom_range(0, 3) != 0);
      clr_ovr  = ($urandom_range(0, 19) == 0);
      rand_cnt();
      tick();
    end
    drain("random");

    // Auto-snapshot instance: a request every 20 cycles with rdy tied high.
    tick();
    rst_a_n = 1'b0;
    tick();
    rst_a_n = 1'b1;
    for (int c = 0; c < 112; c++) begin
      @(negedge clk);
      if (a_done) done_cyc.push_back(c);
      tick();
    end
    check("auto_done_count", done_cyc.size(), 5);
    for (int m = 0; m < done_cyc.size() && m < 5; m++)
      check("auto_done_cycle", done_cyc[m], 20 * m + 27);
    @(negedge clk);
    check("auto_seq",     a_seq, 16'd5);
    check("auto_overrun", a_ovr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
